// File: rtl/vga_frame_timer_pkg.sv
// Shared timing constants and types for the VGA frame timer.
// Defaults describe 640x480 at 60 Hz from a 25 MHz pixel clock.
package vga_frame_timer_pkg;

    localparam int CNT_W = 12;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int FRAME_WIDTH  = DEF_H_ACTIVE;
    localparam int FRAME_HEIGHT = DEF_V_ACTIVE;

    localparam logic DEF_SYNC_POL   = 1'b0;
    localparam int   DEF_PIPE_DEPTH = 0;

    // Syncs travel as "asserted" flags; polarity is applied at the pins.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
    } sync_bundle_t;

endpackage

// File: rtl/vga_frame_timer_sync_delay_line.sv
// Fixed-depth shift register with a synchronous reset value.
// DEPTH of zero degenerates to a plain wire.
module sync_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, reset};
        assign q = d;
    end else begin : g_shift
        logic [WIDTH-1:0] stages [DEPTH];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) stages[i] <= RESET_VAL;
            end else begin
                stages[0] <= d;
                for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
            end
        end

        assign q = stages[DEPTH-1];
    end

endmodule

// File: rtl/vga_frame_timer.sv
// VGA raster timer: pixel coordinates for the image generator, a per-frame
// tick, and blanked, sync-aligned colour at the connector.
module vga_frame_timer
    import vga_frame_timer_pkg::*;
#(
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic SYNC_POL   = DEF_SYNC_POL,
    parameter int   PIPE_DEPTH = DEF_PIPE_DEPTH   // 0..3
) (
    input  logic             CLOCK_25,
    input  logic             reset,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             active,
    output logic             frame_start,
    output logic [7:0]       frame_count,
    input  logic [2:0]       color_in,
    output logic [2:0]       vga_rgb,
    output logic             vga_hsync,
    output logic             vga_vsync
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_cnt, v_cnt, h_next, v_next;
    logic             active_next, hs_next, vs_next, fs_next;
    logic             hs_raw, vs_raw;
    sync_bundle_t     stage0, delayed;

    always_comb begin
        h_next = h_cnt + 1'b1;
        v_next = v_cnt;
        if (h_cnt == H_LAST) begin
            h_next = '0;
            v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end
        active_next = (h_next < H_ACT_C) && (v_next < V_ACT_C);
        hs_next     = (h_next >= HS_START) && (h_next < HS_END);
        vs_next     = (v_next >= VS_START) && (v_next < VS_END);
        fs_next     = (h_next == '0) && (v_next == V_ACT_C);
    end

    // Stage 0 is computed from the next counter values so it describes the
    // counters during the same cycle they hold.
    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            x           <= CNT_W'(1);
            y           <= CNT_W'(1);
            active      <= 1'b1;
            hs_raw      <= 1'b0;
            vs_raw      <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            h_cnt       <= h_next;
            v_cnt       <= v_next;
            x           <= active_next ? h_next + 1'b1 : '0;
            y           <= active_next ? v_next + 1'b1 : '0;
            active      <= active_next;
            hs_raw      <= hs_next;
            vs_raw      <= vs_next;
            frame_start <= fs_next;
            if (fs_next) frame_count <= frame_count + 1'b1;
        end
    end

    assign stage0 = {active, hs_raw, vs_raw};

    sync_delay_line #(
        .WIDTH    ($bits(sync_bundle_t)),
        .DEPTH    (PIPE_DEPTH),
        .RESET_VAL('0)
    ) u_delay (
        .clk  (CLOCK_25),
        .reset(reset),
        .d    (stage0),
        .q    (delayed)
    );

    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            vga_rgb   <= 3'b000;
            vga_hsync <= ~SYNC_POL;
            vga_vsync <= ~SYNC_POL;
        end else begin
            vga_rgb   <= delayed.active ? color_in : 3'b000;
            vga_hsync <= delayed.hsync ? SYNC_POL : ~SYNC_POL;
            vga_vsync <= delayed.vsync ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: tb/tb_vga_frame_timer.sv
// Bench for vga_frame_timer: full-size line checks from a vector table, and
// small-raster instances checked cycle by cycle against a reference model.
module tb_vga_frame_timer;

  localparam int SH_ACT = 8, SH_FP = 2, SH_SY = 3, SH_BP = 3;
  localparam int SH_TOT = SH_ACT + SH_FP + SH_SY + SH_BP;
  localparam int SV_ACT = 6, SV_FP = 2, SV_SY = 2, SV_BP = 2;
  localparam int SV_TOT = SV_ACT + SV_FP + SV_SY + SV_BP;
  localparam int S_FRAME = SH_TOT * SV_TOT;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic rst_c = 1'b1;
  logic rst_s = 1'b1;
  logic [2:0] color_c = 3'b111;
  logic [2:0] color_a = 3'b000;
  logic [2:0] color_b = 3'b000;

  logic [11:0] x_c, y_c, x_a, y_a, x_b, y_b;
  logic act_c, act_a, act_b, fs_c, fs_a, fs_b;
  logic [7:0] fc_c, fc_a, fc_b;
  logic [2:0] rgb_c, rgb_a, rgb_b;
  logic hs_c, vs_c, hs_a, vs_a, hs_b, vs_b;

  int n_cmp = 0;
  int n_bad = 0;

  vga_frame_timer dut_c (
    .CLOCK_25(clk), .reset(rst_c), .x(x_c), .y(y_c), .active(act_c),
    .frame_start(fs_c), .frame_count(fc_c), .color_in(color_c),
    .vga_rgb(rgb_c), .vga_hsync(hs_c), .vga_vsync(vs_c)
  );

  vga_frame_timer #(
    .H_ACTIVE(SH_ACT), .H_FP(SH_FP), .H_SYNC(SH_SY), .H_BP(SH_BP),
    .V_ACTIVE(SV_ACT), .V_FP(SV_FP), .V_SYNC(SV_SY), .V_BP(SV_BP),
    .SYNC_POL(1'b0), .PIPE_DEPTH(0)
  ) dut_a (
    .CLOCK_25(clk), .reset(rst_s), .x(x_a), .y(y_a), .active(act_a),
    .frame_start(fs_a), .frame_count(fc_a), .color_in(color_a),
    .vga_rgb(rgb_a), .vga_hsync(hs_a), .vga_vsync(vs_a)
  );

  vga_frame_timer #(
    .H_ACTIVE(SH_ACT), .H_FP(SH_FP), .H_SYNC(SH_SY), .H_BP(SH_BP),
    .V_ACTIVE(SV_ACT), .V_FP(SV_FP), .V_SYNC(SV_SY), .V_BP(SV_BP),
    .SYNC_POL(1'b1), .PIPE_DEPTH(2)
  ) dut_b (
    .CLOCK_25(clk), .reset(rst_s), .x(x_b), .y(y_b), .active(act_b),
    .frame_start(fs_b), .frame_count(fc_b), .color_in(color_b),
    .vga_rgb(rgb_b), .vga_hsync(hs_b), .vga_vsync(vs_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, required %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- small-raster model and scoreboard ----------------
  logic [4:0] exp_a[$];
  logic [4:0] exp_b[$];
  logic [2:0] xlow_hist[$];
  int t_s = 0;
  int fc_model = 0;

  always begin : small_model
    int h, v, xe, ye;
    logic ae, hse, vse, fse;
    logic [4:0] front;
    @(posedge clk);
    #1;
    if (rst_s) begin
      t_s = 0;
      fc_model = 0;
      exp_a.delete();
      exp_b.delete();
      xlow_hist.delete();
      exp_a.push_back({3'b000, 1'b1, 1'b1});
      repeat (3) exp_b.push_back({3'b000, 1'b0, 1'b0});
    end else begin
      t_s++;
    end
    h = t_s % SH_TOT;
    v = (t_s / SH_TOT) % SV_TOT;
    ae = (h < SH_ACT) && (v < SV_ACT);
    xe = ae ? h + 1 : 0;
    ye = ae ? v + 1 : 0;
    hse = (h >= SH_ACT + SH_FP) && (h < SH_ACT + SH_FP + SH_SY);
    vse = (v >= SV_ACT + SV_FP) && (v < SV_ACT + SV_FP + SV_SY);
    fse = (h == 0) && (v == SV_ACT);
    if (fse) fc_model = (fc_model + 1) % 256;

    check("a_x", x_a, xe);
    check("a_y", y_a, ye);
    check("a_active", act_a, ae);
    check("a_frame_start", fs_a, fse);
    check("a_frame_count", fc_a, fc_model);
    check("b_x", x_b, xe);
    check("b_frame_count", fc_b, fc_model);

    // colour for this cycle: random for A, x[2:0] delayed 2 cycles for B
    color_a = 3'($urandom_range(0, 7));
    xlow_hist.push_back(3'(xe));
    color_b = (xlow_hist.size() > 2) ? xlow_hist[xlow_hist.size() - 3] : 3'b000;

    exp_a.push_back({ae ? color_a : 3'b000, ~hse, ~vse});
    exp_b.push_back({ae ? 3'(xe) : 3'b000, hse, vse});

    if (exp_a.size() == 0) check("a_queue_empty", 0, 1);
    else begin
      front = exp_a.pop_front();
      check("a_vga_rgb", rgb_a, front[4:2]);
      check("a_vga_hsync", hs_a, front[1]);
      check("a_vga_vsync", vs_a, front[0]);
    end
    if (exp_b.size() == 0) check("b_queue_empty", 0, 1);
    else begin
      front = exp_b.pop_front();
      check("b_vga_rgb", rgb_b, front[4:2]);
      check("b_vga_hsync", hs_b, front[1]);
      check("b_vga_vsync", vs_b, front[0]);
    end
    if (xlow_hist.size() > 4) void'(xlow_hist.pop_front());
  end

  // ---------------- full-size vectors ----------------
  typedef struct {
    int          cyc;
    logic [11:0] x;
    logic [11:0] y;
    logic        act;
    logic        hs;
    logic [2:0]  rgb;
  } vec_t;

  vec_t tbl[13];

  initial begin : main
    int tc, lows, first_low, second_low, n7, first7, last7, pulses, last_pulse, tt;
    bit found;
    logic prev_hs;

    tbl[0]  = '{0,    12'd1,   12'd1, 1'b1, 1'b1, 3'd0};
    tbl[1]  = '{1,    12'd2,   12'd1, 1'b1, 1'b1, 3'd7};
    tbl[2]  = '{639,  12'd640, 12'd1, 1'b1, 1'b1, 3'd7};
    tbl[3]  = '{640,  12'd0,   12'd0, 1'b0, 1'b1, 3'd7};
    tbl[4]  = '{641,  12'd0,   12'd0, 1'b0, 1'b1, 3'd0};
    tbl[5]  = '{656,  12'd0,   12'd0, 1'b0, 1'b1, 3'd0};
    tbl[6]  = '{657,  12'd0,   12'd0, 1'b0, 1'b0, 3'd0};
    tbl[7]  = '{752,  12'd0,   12'd0, 1'b0, 1'b0, 3'd0};
    tbl[8]  = '{753,  12'd0,   12'd0, 1'b0, 1'b1, 3'd0};
    tbl[9]  = '{799,  12'd0,   12'd0, 1'b0, 1'b1, 3'd0};
    tbl[10] = '{800,  12'd1,   12'd2, 1'b1, 1'b1, 3'd0};
    tbl[11] = '{801,  12'd2,   12'd2, 1'b1, 1'b1, 3'd7};
    tbl[12] = '{1457, 12'd0,   12'd0, 1'b0, 1'b0, 3'd0};

    repeat (3) @(posedge clk);
    @(negedge clk) rst_c = 1'b0;
    tc = 0;
    check("c_reset_frame_count", fc_c, 0);
    check("c_reset_vsync", vs_c, 1);
    for (int i = 0; i < 13; i++) begin
      while (tc < tbl[i].cyc) begin
        @(posedge clk);
        #3;
        tc++;
      end
      check($sformatf("c_x[%0d]", tbl[i].cyc), x_c, tbl[i].x);
      check($sformatf("c_y[%0d]", tbl[i].cyc), y_c, tbl[i].y);
      check($sformatf("c_active[%0d]", tbl[i].cyc), act_c, tbl[i].act);
      check($sformatf("c_hsync[%0d]", tbl[i].cyc), hs_c, tbl[i].hs);
      check($sformatf("c_rgb[%0d]", tbl[i].cyc), rgb_c, tbl[i].rgb);
    end

    // Hsync width/period and visible colour window over two full lines.
    @(negedge clk) rst_c = 1'b1;
    @(negedge clk) rst_c = 1'b0;
    lows = 0; first_low = -1; second_low = -1; n7 = 0; first7 = -1; last7 = -1;
    prev_hs = 1'b1;
    for (int t = 0; t < 1600; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #3;
      end
      if (t < 800 && hs_c == 1'b0) lows++;
      if (prev_hs && !hs_c) begin
        if (first_low < 0) first_low = t;
        else if (second_low < 0) second_low = t;
      end
      prev_hs = hs_c;
      if (t < 800 && rgb_c == 3'b111) begin
        n7++;
        if (first7 < 0) first7 = t;
        last7 = t;
      end
    end
    check("c_hsync_low_cycles", lows, 96);
    check("c_hsync_first_fall", first_low, 657);
    check("c_hsync_period", second_low - first_low, 800);
    check("c_rgb_visible_cycles", n7, 640);
    check("c_rgb_first_visible", first7, 1);
    check("c_rgb_last_visible", last7, 640);

    // Small raster: frame period and frame_count wrap after 256 pulses.
    @(negedge clk) rst_s = 1'b0;
    pulses = 0; last_pulse = -1;
    for (int k = 0; k < 256 * S_FRAME + 200 && pulses < 256; k++) begin
      @(posedge clk);
      #3;
      if (fs_a) begin
        pulses++;
        if (last_pulse >= 0) check("a_frame_period", t_s - last_pulse, S_FRAME);
        else check("a_first_frame_start", t_s, SV_ACT * SH_TOT);
        last_pulse = t_s;
        if (pulses == 256) check("a_frame_count_wrap", fc_a, 0);
      end
    end
    check("a_pulse_count", pulses, 256);

    // Mid-frame reset while inside the visible area.
    found = 0;
    for (int k = 0; k < 2 * S_FRAME && !found; k++) begin
      @(posedge clk);
      #3;
      if (t_s % S_FRAME == 3 * SH_TOT + 4) found = 1;
    end
    check("mid_reset_reached", found, 1);
    @(negedge clk) rst_s = 1'b1;
    @(negedge clk) rst_s = 1'b0;
    check("mid_x", x_a, 1);
    check("mid_y", y_a, 1);
    check("mid_rgb", rgb_a, 0);
    check("mid_hsync_a", hs_a, 1);
    check("mid_vsync_a", vs_a, 1);
    check("mid_hsync_b", hs_b, 0);
    check("mid_frame_count", fc_a, 0);
    check("mid_frame_start", fs_a, 0);
    tt = 0;
    found = 0;
    for (int k = 0; k < 2 * S_FRAME && !found; k++) begin
      @(posedge clk);
      #3;
      tt++;
      if (tt == 3) check("b_first_visible_rgb", rgb_b, 1);
      if (fs_a) found = 1;
    end
    check("mid_next_frame_start", tt, SV_ACT * SH_TOT);
    repeat (300) @(posedge clk);
    #3;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #(40 * 80000);
    $display("FAIL watchdog: simulation did not complete, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
